// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte handshakes plus the shared UART transmitter write port
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 2);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   last;
    logic [8*NUM_REQ-1:0] wdata;
    logic [NUM_REQ-1:0]   ack;
    logic [NUM_REQ-1:0]   gnt;
    logic                 tx_rdy;
    logic [7:0]           tx_data;
    logic                 tx_wen;
    logic                 frame_abort;
    modport master (input req, last, wdata, tx_rdy, output ack, gnt, tx_data, tx_wen, frame_abort);
    modport slave (output req, last, wdata, tx_rdy, input ack, gnt, tx_data, tx_wen, frame_abort);
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: frame-locked round-robin sharing of one UART transmitter between NUM_REQ producers
module uart_tx_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 255
) (
    input logic               clk,
    input logic               rst,
    uart_tx_arbiter_if.master bus
);
    localparam int PW = (NUM_REQ > 2) ? 2 : 1;
    typedef enum logic [1:0] {IDLE, WAIT_RDY, WRITE} state_t;
    state_t state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d, ack_q, ack_d;
    logic [7:0] tx_data_q, tx_data_d, cnt_q, cnt_d;
    logic tx_wen_q, tx_wen_d, abort_q, abort_d, last_q, last_d, sent_q, sent_d;
    logic [PW-1:0] ptr_q, ptr_d, own_q, own_d, pick;
    logic found;
    always_comb begin
        pick = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && bus.req[(int'(ptr_q) + k) % NUM_REQ]) begin
                pick = PW'((int'(ptr_q) + k) % NUM_REQ);
                found = 1'b1;
            end
        end
    end
    always_comb begin
        state_d = state_q;
        gnt_d = gnt_q;
        ack_d = '0;
        tx_data_d = tx_data_q;
        tx_wen_d = tx_wen_q;
        abort_d = 1'b0;
        cnt_d = cnt_q;
        last_d = last_q;
        sent_d = sent_q;
        ptr_d = ptr_q;
        own_d = own_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d = NUM_REQ'(1) << pick;
                    own_d = pick;
                    sent_d = 1'b0;
                    cnt_d = '0;
                    state_d = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (bus.req[own_q]) begin
                    cnt_d = '0;
                    if (bus.tx_rdy) begin
                        tx_data_d = bus.wdata[8*own_q +: 8];
                        tx_wen_d = 1'b0;
                        last_d = bus.last[own_q];
                        sent_d = 1'b1;
                        state_d = WRITE;
                    end
                end else if (!sent_q) begin
                    gnt_d = '0;
                    state_d = IDLE;
                end else if (bus.tx_rdy) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == 8'(TIMEOUT)) begin
                        gnt_d = '0;
                        abort_d = 1'b1;
                        ptr_d = own_q;
                        cnt_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            WRITE: begin
                if (!bus.tx_rdy) begin
                    tx_wen_d = 1'b1;
                    ack_d = NUM_REQ'(1) << own_q;
                    state_d = last_q ? IDLE : WAIT_RDY;
                    gnt_d = last_q ? '0 : gnt_q;
                    ptr_d = last_q ? own_q : ptr_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q <= '0;
            ack_q <= '0;
            tx_data_q <= 8'h00;
            tx_wen_q <= 1'b1;
            abort_q <= 1'b0;
            cnt_q <= '0;
            last_q <= 1'b0;
            sent_q <= 1'b0;
            ptr_q <= PW'(NUM_REQ - 1);
            own_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q <= gnt_d;
            ack_q <= ack_d;
            tx_data_q <= tx_data_d;
            tx_wen_q <= tx_wen_d;
            abort_q <= abort_d;
            cnt_q <= cnt_d;
            last_q <= last_d;
            sent_q <= sent_d;
            ptr_q <= ptr_d;
            own_q <= own_d;
        end
    end
    assign bus.gnt = gnt_q;
    assign bus.ack = ack_q;
    assign bus.tx_data = tx_data_q;
    assign bus.tx_wen = tx_wen_q;
    assign bus.frame_abort = abort_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with requester drivers and a UART transmitter model
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    uart_tx_arbiter_if #(.NUM_REQ(2)) bus();
    uart_tx_arbiter #(.NUM_REQ(2), .TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    int checks = 0;
    int failures = 0;
    logic [8:0] src0[$];
    logic [8:0] src1[$];
    logic [9:0] exp_q[$];
    logic [9:0] e;
    logic [1:0] exp_own = 2'b00;
    logic [1:0] prev_gnt = 2'b00;
    logic prev_wen = 1'b1;
    logic tx_low = 1'b0;
    int dly = 0, low_cnt = 0, idle_cnt = 0;
    int acks0 = 0, acks1 = 0, aborts = 0, wen_lows = 0, direct_switch = 0;
    int a0, a1, ab, wl;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic sync();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_gnt(input logic [1:0] g);
        int n = 0;
        while (bus.gnt != g && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_gnt", 32'(bus.gnt), 32'(g));
    endtask
    task automatic drain(input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || src0.size() != 0 || src1.size() != 0 || bus.gnt != 2'b00) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", 32'(n < limit), 32'd1);
    endtask
    always @(negedge clk) begin
        if (bus.frame_abort) aborts++;
        if (bus.ack != 2'b00) begin
            check("ack_owner", 32'(bus.ack), 32'(exp_own));
            if (bus.ack[0]) acks0++;
            if (bus.ack[1]) acks1++;
        end
        if (!bus.tx_wen) wen_lows++;
        if (prev_gnt != 2'b00 && bus.gnt != 2'b00 && bus.gnt != prev_gnt) direct_switch++;
        prev_gnt = bus.gnt;
        if (dly != 0) begin
            dly--;
            if (dly == 0) low_cnt = 2;
        end else if (low_cnt != 0) begin
            low_cnt--;
        end
        if (!bus.tx_wen && prev_wen) begin
            if (exp_q.size() == 0) begin
                check("tx_unexpected", 32'({bus.gnt, bus.tx_data}), 32'h3ff);
            end else begin
                e = exp_q.pop_front();
                check("tx_byte", 32'({bus.gnt, bus.tx_data}), 32'(e));
                exp_own = e[9:8];
            end
            dly = 3;
        end
        prev_wen = bus.tx_wen;
        bus.tx_rdy = !tx_low && low_cnt == 0;
        if (bus.ack[0]) void'(src0.pop_front());
        bus.req[0] = src0.size() != 0;
        if (src0.size() != 0) {bus.last[0], bus.wdata[7:0]} = src0[0];
        if (bus.ack[1]) void'(src1.pop_front());
        bus.req[1] = src1.size() != 0;
        if (src1.size() != 0) {bus.last[1], bus.wdata[15:8]} = src1[0];
        if (bus.req[1]) idle_cnt = 0;
        else if (bus.gnt == 2'b10 && bus.tx_wen && bus.tx_rdy) idle_cnt++;
    end
    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_wen", 32'(bus.tx_wen), 32'd1);
        check("rst_data", 32'(bus.tx_data), 32'd0);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_abort", 32'(bus.frame_abort), 32'd0);
        rst = 1'b0;
        sync();
        src0.push_back({1'b1, 8'hA4});
        exp_q.push_back({2'b01, 8'hA4});
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            if (bus.req[0]) break;
        end
        @(negedge clk);
        check("single_gnt", 32'(bus.gnt), 32'd1);
        @(negedge clk);
        check("single_wen", 32'(bus.tx_wen), 32'd0);
        check("single_data", 32'(bus.tx_data), 32'hA4);
        for (int i = 0; i < 20 && bus.ack == 2'b00; i++) @(negedge clk);
        check("single_ack", 32'(bus.ack), 32'd1);
        check("single_gnt_clr", 32'(bus.gnt), 32'd0);
        check("single_wen_hi", 32'(bus.tx_wen), 32'd1);
        @(negedge clk);
        check("single_ack_pulse", 32'(bus.ack), 32'd0);
        drain(100);
        sync();
        src0.push_back({1'b0, 8'h32});
        src0.push_back({1'b1, 8'h81});
        exp_q.push_back({2'b01, 8'h32});
        exp_q.push_back({2'b01, 8'h81});
        exp_q.push_back({2'b10, 8'h55});
        wait_gnt(2'b01);
        sync();
        src1.push_back({1'b1, 8'h55});
        drain(200);
        check("lock_gap", 32'(direct_switch), 32'd0);
        sync();
        a0 = acks0;
        a1 = acks1;
        for (int k = 0; k < 4; k++) begin
            src0.push_back({1'b1, 8'hB0 + 8'(k)});
            src1.push_back({1'b1, 8'hC0 + 8'(k)});
            exp_q.push_back({2'b01, 8'hB0 + 8'(k)});
            exp_q.push_back({2'b10, 8'hC0 + 8'(k)});
        end
        drain(400);
        check("rr_acks0", 32'(acks0 - a0), 32'd4);
        check("rr_acks1", 32'(acks1 - a1), 32'd4);
        sync();
        ab = aborts;
        src1.push_back({1'b0, 8'h10});
        exp_q.push_back({2'b10, 8'h10});
        exp_q.push_back({2'b01, 8'h66});
        wait_gnt(2'b10);
        sync();
        src0.push_back({1'b1, 8'h66});
        for (int i = 0; i < 100 && !bus.frame_abort; i++) @(negedge clk);
        check("to_abort", 32'(bus.frame_abort), 32'd1);
        check("to_gnt", 32'(bus.gnt), 32'd0);
        check("to_idle_cycles", 32'(idle_cnt), 32'd4);
        @(negedge clk);
        check("to_abort_pulse", 32'(bus.frame_abort), 32'd0);
        check("to_regrant", 32'(bus.gnt), 32'd1);
        drain(200);
        check("to_abort_count", 32'(aborts - ab), 32'd1);
        sync();
        tx_low = 1'b1;
        wl = wen_lows;
        a0 = acks0;
        ab = aborts;
        src0.push_back({1'b1, 8'h77});
        exp_q.push_back({2'b01, 8'h77});
        repeat (500) @(negedge clk);
        check("bp_wen", 32'(wen_lows - wl), 32'd0);
        check("bp_ack", 32'(acks0 - a0), 32'd0);
        check("bp_abort", 32'(aborts - ab), 32'd0);
        check("bp_gnt", 32'(bus.gnt), 32'd1);
        tx_low = 1'b0;
        drain(100);
        check("bp_ack_after", 32'(acks0 - a0), 32'd1);
        sync();
        src0.push_back({1'b1, 8'hC3});
        exp_q.push_back({2'b01, 8'hC3});
        exp_q.push_back({2'b01, 8'hC3});
        exp_q.push_back({2'b10, 8'h5A});
        for (int i = 0; i < 50 && bus.tx_wen; i++) @(negedge clk);
        check("rmw_wen_lo", 32'(bus.tx_wen), 32'd0);
        a0 = acks0 + acks1;
        rst = 1'b1;
        src1.push_back({1'b1, 8'h5A});
        @(negedge clk);
        check("rmw_wen", 32'(bus.tx_wen), 32'd1);
        check("rmw_gnt", 32'(bus.gnt), 32'd0);
        check("rmw_ack", 32'(bus.ack), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 20 && bus.gnt == 2'b00; i++) @(negedge clk);
        check("rmw_first", 32'(bus.gnt), 32'd1);
        drain(200);
        check("rmw_acks", 32'(acks0 + acks1 - a0), 32'd2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between NUM_REQ byte producers, e.g. the sonar/servo control unit telemetry and a status/debug reporter. Round-robin arbitration is done per frame: a granted requester keeps the transmitter until its byte flagged "last" has been sent, so multi-byte records such as distance+angle pairs are never interleaved. It drives the transmitter with the existing tx_rdy / active-low write-enable handshake.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
TIMEOUT, 255, idle cycles allowed mid-frame before the grant is revoked (1..255, 8-bit counter)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
req  input  NUM_REQ  per-requester byte valid; held until matching ack
last  input  NUM_REQ  per-requester: current byte ends the frame
wdata  input  8*NUM_REQ  per-requester byte; slice i = bits [8i+7:8i]
ack  output  NUM_REQ  one-cycle pulse: byte i accepted by transmitter
gnt  output  NUM_REQ  one-hot current owner; all zero when idle
tx_rdy  input  1  transmitter ready for a new byte
tx_data  output  8  byte to transmitter
tx_wen  output  1  active-low write strobe to transmitter
frame_abort  output  1  one-cycle pulse: grant revoked by timeout

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, gnt=0, ack=0, tx_wen=1, tx_data=8'h00, frame_abort=0, timeout count=0, rr pointer=NUM_REQ-1 so requester 0 has top priority first. Reset mid-write drops tx_wen to 1 on that edge; the byte in flight is not acked.
- All outputs are registered.
- State IDLE: if req!=0, grant the first set bit searching upward from pointer+1 (mod NUM_REQ). gnt is registered next edge -> WAIT_RDY. Grant appears 1 cycle after req.
- State WAIT_RDY (owner g):
  - tx_rdy=1 and req[g]=1: tx_data<=wdata[g], tx_wen<=0, latch last[g] -> WRITE.
  - req[g]=0 and no byte sent yet this frame: release, gnt<=0 -> IDLE. No abort pulse.
  - req[g]=0 mid-frame: increment timeout count. At count==TIMEOUT: gnt<=0, frame_abort pulses 1 cycle, pointer<=g -> IDLE.
  - Count clears whenever req[g]=1.
  - tx_rdy=0 waits indefinitely; no timeout applies.
- State WRITE: hold tx_wen=0 and tx_data stable until tx_rdy=0 is sampled. Then tx_wen<=1 and ack[g]<=1 for one cycle.
  - If the latched last=1: gnt<=0, pointer<=g -> IDLE.
  - Else -> WAIT_RDY, still owning the frame.
- Requester i must drop req or present its next byte in the cycle after ack[i]. The arbiter does not re-sample req[g] in the ack cycle: it sits in WAIT_RDY, and tx_rdy is low there anyway.
- Minimum spacing between bytes is set by the transmitter's tx_rdy. Best case per byte: 1 cycle WAIT_RDY + WRITE held until tx_rdy falls.
- Simultaneous requests in IDLE: the round-robin winner is granted. Losers keep req high and are not acked.
- req changes from non-owners during a frame are ignored.
- After a frame ends, IDLE can re-grant on the next edge, so the minimum turnaround is 1 idle cycle.
- Changes to last or wdata of the owner while in WRITE are ignored; values are latched on entry.
- gnt is never multi-hot; ack is asserted only for the owner.

Test Plan:
- Single byte: after reset, req=2'b01, last=2'b01, wdata0=8'hA4, tx_rdy=1 -> gnt=01 next cycle, tx_wen=0 with tx_data=A4. Model drops tx_rdy 3 cycles later -> tx_wen=1, ack=01 one cycle, gnt=00.
- Frame lock: requester 0 sends 2-byte frame (8'h32 last=0, 8'h81 last=1) while req1 is held high with 8'h55 -> transmitter sees 32, 81, then 55. gnt1 asserts only after gnt0 clears.
- Round-robin: both requesters continuously send 1-byte frames, tx model always ready -> grant order 0,1,0,1 over 8 frames; the ack count is equal for both.
- Timeout: requester 1 sends 8'h10 last=0, then holds req1=0 with TIMEOUT=4 -> frame_abort pulses on the 4th idle cycle, gnt=00. Pending req0 is granted next.
- Backpressure: tx_rdy=0 for 500 cycles with req0 high -> no timeout, tx_wen stays 1, no ack. Raise tx_rdy -> byte written normally.
- Reset mid-write: assert rst while tx_wen=0 -> next edge tx_wen=1, gnt=0, no ack. After release, requester 0 wins first.
